// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and the shared
// datapath: the decoded opcode and memory handshake flow into the controller,
// and every write-enable, mux select and memory strobe flows back out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       memready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal;

  // Controller side: consumes opcode/memready, drives the datapath controls.
  modport master (
    input  opcode,
    input  memready,
    output PCWrite,
    output PCWriteCond,
    output IorD,
    output MemRead,
    output MemWrite,
    output IRWrite,
    output MemtoReg,
    output RegDst,
    output RegWrite,
    output ALUSrcA,
    output ALUSrcB,
    output ALUOp,
    output PCSource,
    output state,
    output illegal
  );

  // Datapath side: supplies opcode/memready, receives the controls.
  modport slave (
    output opcode,
    output memready,
    input  PCWrite,
    input  PCWriteCond,
    input  IorD,
    input  MemRead,
    input  MemWrite,
    input  IRWrite,
    input  MemtoReg,
    input  RegDst,
    input  RegWrite,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ALUOp,
    input  PCSource,
    input  state,
    input  illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit. Moore FSM that walks each instruction through
// fetch, decode and its execute/memory/writeback steps, stalling in the memory
// states until memready. The only non-Moore outputs are IRWrite and PCWrite in
// FETCH, which are gated by memready so the IR/PC update only on the cycle the
// instruction word actually arrives.
module multicycle_control (
  input  logic                   clk,
  input  logic                   clr,
  multicycle_control_if.master   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       ior_d_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       mem_to_reg_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_source_s;

  // State and sticky illegal-opcode flag; clr overrides any pending transition.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state selection and per-state control decode (all controls default low).
  always_comb begin
    state_d         = S_FETCH;
    illegal_d       = illegal_q;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    ior_d_s         = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'd0;
    alu_op_s        = 2'd0;
    pc_source_s     = 2'd0;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed every fetch cycle, but only committed (with the
        // IR load) in the cycle memory reports the instruction is ready.
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'd1;
        if (bus.memready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
          state_d    = S_FETCH;
        end
      end

      S_DECODE: begin
        // Branch target (PC + imm<<2) is precomputed into ALUOut here.
        alu_src_b_s = 2'd3;
        case (bus.opcode)
          OP_LW:    state_d = S_MEMADR;
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXEC;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_ADDIEX;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        // Only lw and sw reach this state, so anything not sw is a load.
        if (bus.opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end

      S_MEMRD: begin
        mem_read_s = 1'b1;
        ior_d_s    = 1'b1;
        if (bus.memready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end

      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        reg_dst_s    = 1'b0;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        // Write strobe is held for the whole stall so memory sees a stable request.
        mem_write_s = 1'b1;
        ior_d_s     = 1'b1;
        if (bus.memready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end

      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd0;
        alu_op_s    = 2'd2;
        state_d     = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        mem_to_reg_s = 1'b0;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        // PC takes the precomputed target from ALUOut only when the compare is zero.
        alu_src_a_s     = 1'b1;
        alu_src_b_s     = 2'd0;
        alu_op_s        = 2'd1;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'd1;
        state_d         = S_FETCH;
      end

      S_JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'd2;
        state_d     = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        alu_op_s    = 2'd0;
        state_d     = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        state_d      = S_FETCH;
      end

      default: begin
        // Encodings 12-15 are unreachable; recover to FETCH with all controls low.
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.PCWrite     = pc_write_s;
  assign bus.PCWriteCond = pc_write_cond_s;
  assign bus.IorD        = ior_d_s;
  assign bus.MemRead     = mem_read_s;
  assign bus.MemWrite    = mem_write_s;
  assign bus.IRWrite     = ir_write_s;
  assign bus.MemtoReg    = mem_to_reg_s;
  assign bus.RegDst      = reg_dst_s;
  assign bus.RegWrite    = reg_write_s;
  assign bus.ALUSrcA     = alu_src_a_s;
  assign bus.ALUSrcB     = alu_src_b_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.PCSource    = pc_source_s;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control. Each record gives the
// inputs for one cycle and the state/controls expected in that same cycle,
// before the rising edge commits the transition.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Packed control word, MSB first:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
  localparam logic [15:0] C_FETCH  = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] C_FSTALL = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] C_DECODE = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] C_MEMADR = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_MEMRD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_MEMWB  = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] C_MEMWR  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_EXEC   = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [15:0] C_ALUWB  = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] C_BRANCH = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] C_JUMP   = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [15:0] C_ADDIEX = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_ADDIWB = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

  typedef struct {
    logic        clr;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
  } vec_t;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  vec_t tbl [64];
  int   n_vec;
  logic watch;
  int   pulse_cnt;

  multicycle_control_if ifc ();

  multicycle_control dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts any MemWrite/RegWrite pulse while a reset-abort window is watched.
  always @(negedge clk) begin
    if (watch && (ifc.MemWrite || ifc.RegWrite)) pulse_cnt = pulse_cnt + 1;
  end

  function automatic logic [15:0] ctrl_now();
    return {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead, ifc.MemWrite,
            ifc.IRWrite, ifc.MemtoReg, ifc.RegDst, ifc.RegWrite, ifc.ALUSrcA,
            ifc.ALUSrcB, ifc.ALUOp, ifc.PCSource};
  endfunction

  task automatic add(input logic c, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [15:0] ctrl, input logic ill);
    tbl[n_vec].clr  = c;
    tbl[n_vec].op   = op;
    tbl[n_vec].mr   = mr;
    tbl[n_vec].st   = st;
    tbl[n_vec].ctrl = ctrl;
    tbl[n_vec].ill  = ill;
    n_vec = n_vec + 1;
  endtask

  // Apply one cycle of inputs, compare current outputs, then clock.
  task automatic step(input string name, input logic c, input logic [5:0] op,
                      input logic mr, input logic [3:0] st, input logic [15:0] ctrl,
                      input logic ill);
    logic [15:0] got;
    clr          = c;
    ifc.opcode   = op;
    ifc.memready = mr;
    #1;
    got = ctrl_now();
    checks = checks + 1;
    if (ifc.state !== st) begin
      failures = failures + 1;
      $display("FAIL %s state got=%0d exp=%0d", name, ifc.state, st);
    end
    checks = checks + 1;
    if (got !== ctrl) begin
      failures = failures + 1;
      $display("FAIL %s ctrl got=%b exp=%b", name, got, ctrl);
    end
    checks = checks + 1;
    if (ifc.illegal !== ill) begin
      failures = failures + 1;
      $display("FAIL %s illegal got=%b exp=%b", name, ifc.illegal, ill);
    end
    checks = checks + 1;
    if (ifc.MemRead === 1'b1 && ifc.MemWrite === 1'b1) begin
      failures = failures + 1;
      $display("FAIL %s rd_wr_excl got=11 exp=not both", name);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    n_vec     = 0;
    watch     = 1'b0;
    pulse_cnt = 0;
    clr          = 1'b1;
    ifc.opcode   = OP_R;
    ifc.memready = 1'b1;
    @(posedge clk);
    #1;

    // Second reset cycle: FETCH with memready high.
    add(1'b1, OP_LW,   1'b1, 4'd0,  C_FETCH,  1'b0);
    // lw, memready ignored outside memory states, one MEMRD stall.
    add(1'b0, OP_LW,   1'b1, 4'd0,  C_FETCH,  1'b0);
    add(1'b0, OP_LW,   1'b0, 4'd1,  C_DECODE, 1'b0);
    add(1'b0, OP_LW,   1'b0, 4'd2,  C_MEMADR, 1'b0);
    add(1'b0, OP_LW,   1'b0, 4'd3,  C_MEMRD,  1'b0);
    add(1'b0, OP_LW,   1'b1, 4'd3,  C_MEMRD,  1'b0);
    add(1'b0, OP_LW,   1'b0, 4'd4,  C_MEMWB,  1'b0);
    // sw with 3 stall cycles in MEMWR.
    add(1'b0, OP_SW,   1'b1, 4'd0,  C_FETCH,  1'b0);
    add(1'b0, OP_SW,   1'b1, 4'd1,  C_DECODE, 1'b0);
    add(1'b0, OP_SW,   1'b1, 4'd2,  C_MEMADR, 1'b0);
    add(1'b0, OP_SW,   1'b0, 4'd5,  C_MEMWR,  1'b0);
    add(1'b0, OP_SW,   1'b0, 4'd5,  C_MEMWR,  1'b0);
    add(1'b0, OP_SW,   1'b0, 4'd5,  C_MEMWR,  1'b0);
    add(1'b0, OP_SW,   1'b1, 4'd5,  C_MEMWR,  1'b0);
    // R-type with one fetch stall, then beq, then j.
    add(1'b0, OP_R,    1'b0, 4'd0,  C_FSTALL, 1'b0);
    add(1'b0, OP_R,    1'b1, 4'd0,  C_FETCH,  1'b0);
    add(1'b0, OP_R,    1'b1, 4'd1,  C_DECODE, 1'b0);
    add(1'b0, OP_R,    1'b1, 4'd6,  C_EXEC,   1'b0);
    add(1'b0, OP_R,    1'b1, 4'd7,  C_ALUWB,  1'b0);
    add(1'b0, OP_BEQ,  1'b1, 4'd0,  C_FETCH,  1'b0);
    add(1'b0, OP_BEQ,  1'b1, 4'd1,  C_DECODE, 1'b0);
    add(1'b0, OP_BEQ,  1'b1, 4'd8,  C_BRANCH, 1'b0);
    add(1'b0, OP_J,    1'b1, 4'd0,  C_FETCH,  1'b0);
    add(1'b0, OP_J,    1'b1, 4'd1,  C_DECODE, 1'b0);
    add(1'b0, OP_J,    1'b1, 4'd9,  C_JUMP,   1'b0);
    // Illegal opcode, flag survives a following addi, cleared by clr.
    add(1'b0, OP_BAD,  1'b1, 4'd0,  C_FETCH,  1'b0);
    add(1'b0, OP_BAD,  1'b1, 4'd1,  C_DECODE, 1'b0);
    add(1'b0, OP_ADDI, 1'b1, 4'd0,  C_FETCH,  1'b1);
    add(1'b0, OP_ADDI, 1'b1, 4'd1,  C_DECODE, 1'b1);
    add(1'b0, OP_ADDI, 1'b1, 4'd10, C_ADDIEX, 1'b1);
    add(1'b0, OP_ADDI, 1'b1, 4'd11, C_ADDIWB, 1'b1);
    add(1'b1, OP_ADDI, 1'b1, 4'd0,  C_FETCH,  1'b1);
    add(1'b0, OP_ADDI, 1'b0, 4'd0,  C_FSTALL, 1'b0);
    add(1'b0, OP_ADDI, 1'b0, 4'd0,  C_FSTALL, 1'b0);

    for (int i = 0; i < n_vec; i++) begin
      step($sformatf("vec%0d", i), tbl[i].clr, tbl[i].op, tbl[i].mr,
           tbl[i].st, tbl[i].ctrl, tbl[i].ill);
    end

    // Reset aborts a stalled load: back to FETCH, no write of any kind.
    watch = 1'b1;
    step("rdabort_f", 1'b0, OP_LW, 1'b1, 4'd0, C_FETCH,  1'b0);
    step("rdabort_d", 1'b0, OP_LW, 1'b1, 4'd1, C_DECODE, 1'b0);
    step("rdabort_a", 1'b0, OP_LW, 1'b1, 4'd2, C_MEMADR, 1'b0);
    step("rdabort_h", 1'b0, OP_LW, 1'b0, 4'd3, C_MEMRD,  1'b0);
    step("rdabort_c", 1'b1, OP_LW, 1'b0, 4'd3, C_MEMRD,  1'b0);
    step("rdabort_0", 1'b0, OP_LW, 1'b0, 4'd0, C_FSTALL, 1'b0);
    watch = 1'b0;
    checks = checks + 1;
    if (pulse_cnt != 0) begin
      failures = failures + 1;
      $display("FAIL rdabort_pulses got=%0d exp=0", pulse_cnt);
    end

    // Reset aborts a stalled store; then a fresh fetch proceeds normally.
    step("wrabort_f", 1'b0, OP_SW, 1'b1, 4'd0, C_FETCH,  1'b0);
    step("wrabort_d", 1'b0, OP_SW, 1'b1, 4'd1, C_DECODE, 1'b0);
    step("wrabort_a", 1'b0, OP_SW, 1'b1, 4'd2, C_MEMADR, 1'b0);
    step("wrabort_h", 1'b0, OP_SW, 1'b0, 4'd5, C_MEMWR,  1'b0);
    step("wrabort_c", 1'b1, OP_SW, 1'b0, 4'd5, C_MEMWR,  1'b0);
    step("wrabort_0", 1'b0, OP_J,  1'b1, 4'd0, C_FETCH,  1'b0);
    step("wrabort_1", 1'b0, OP_J,  1'b1, 4'd1, C_DECODE, 1'b0);
    step("wrabort_9", 1'b0, OP_J,  1'b1, 4'd9, C_JUMP,   1'b0);

    // Reset during a FETCH stall keeps FETCH and stays quiet until memready.
    step("fsabort_h", 1'b0, OP_R, 1'b0, 4'd0, C_FSTALL, 1'b0);
    step("fsabort_c", 1'b1, OP_R, 1'b0, 4'd0, C_FSTALL, 1'b0);
    step("fsabort_0", 1'b0, OP_R, 1'b1, 4'd0, C_FETCH,  1'b0);
    step("fsabort_1", 1'b0, OP_R, 1'b1, 4'd1, C_DECODE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control unit that sequences the shared 32-bit datapath built from our register, 4:1 mux, sign-extend, shift-left-2 and jump-concatenate components. It is a Moore FSM:
- It decodes the IR opcode.
- It drives every register write-enable, mux select and memory strobe each cycle.
- It stalls on a memory-ready handshake.

It sits between the instruction register and the datapath, one instance per core.

## Interface
Parameters:
- none (opcodes fixed: R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, j 6'b000010, addi 6'b001000)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- clr  in  1  reset, synchronous, active-high
- opcode  in  6  IR[31:26], sampled in DECODE
- memready  in  1  memory access complete this cycle
- PCWrite  out  1  unconditional PC write enable
- PCWriteCond  out  1  PC write enable qualified externally by ALU zero
- IorD  out  1  memory address select: 0 PC, 1 ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register write enable
- MemtoReg  out  1  register write data: 0 ALUOut, 1 MDR
- RegDst  out  1  destination: 0 rt, 1 rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 PC, 1 register A
- ALUSrcB  out  2  mux4to1 select: 0 B, 1 constant 4, 2 sign-extended imm, 3 sign-extended imm shifted left 2
- ALUOp  out  2  0 add, 1 subtract, 2 use funct field
- PCSource  out  2  mux4to1 select: 0 ALU result, 1 ALUOut, 2 jump address {PC[31:28], addr<<2}
- state  out  4  current state encoding (debug)
- illegal  out  1  sticky unsupported-opcode flag

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12-15 are unreachable and go to FETCH.
- Outputs are a pure function of `state`. Every output not listed for a state is 0.
- FETCH:
  - Asserts MemRead, IRWrite, ALUSrcB=1, PCWrite.
  - While memready=0: IRWrite and PCWrite are forced to 0 and the state holds.
  - memready=1: go to DECODE.
- DECODE:
  - Asserts ALUSrcB=3, which precomputes the branch target.
  - Next state by opcode: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX.
  - Any other opcode: set `illegal`, go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2. lw→MEMRD, sw→MEMWR.
- MEMRD: MemRead, IorD=1. Holds until memready=1, then goes to MEMWB.
- MEMWB: RegWrite, MemtoReg=1, RegDst=0. Go to FETCH.
- MEMWR:
  - Asserts MemWrite, IorD=1.
  - Holds until memready=1, then goes to FETCH.
  - MemWrite stays asserted during the hold.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Go to ALUWB.
- ALUWB: RegWrite, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond, PCSource=1. Go to FETCH.
- JUMP: PCWrite, PCSource=2. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Go to ADDIWB.
- ADDIWB: RegWrite, RegDst=0, MemtoReg=0. Go to FETCH.
- `illegal`: set on the DECODE→FETCH edge for an unsupported opcode. Cleared only by clr.
- opcode is only consumed in DECODE, MEMADR and (implicitly) the states that follow. The IR must hold it stable, which it does because IRWrite is 0 outside FETCH.

## Timing
- Reset:
  - clr=1 at a rising edge sets state=FETCH and illegal=0, overriding any transition, including mid-hold in MEMRD, MEMWR or FETCH.
  - Reset values in the cycle after reset: MemRead=1, ALUSrcB=1, IRWrite=0 and PCWrite=0 unless memready=1. All other outputs 0, state=0, illegal=0.
- IRWrite and PCWrite in FETCH are `memready`-gated combinationally. These are the only outputs that are not pure Moore.
- Cycle counts with memready tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
- Each cycle memready is low in FETCH, MEMRD or MEMWR adds one cycle.
- memready is ignored in all other states.
- MemRead and MemWrite are never asserted in the same cycle.

## Test plan
- Reset: hold clr=1 for 2 cycles with memready=1 → state=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=1, illegal=0.
- lw, memready=1: opcode=6'b100011 → state sequence 0,1,2,3,4,0. RegWrite=1 with MemtoReg=1 only in state 4.
- sw with memready low for 3 cycles in MEMWR: opcode=6'b101011 → state 5 held for 4 cycles with MemWrite=1 throughout, then state 0. RegWrite is never 1.
- R-type then beq then j, back to back → sequences 0,1,6,7 / 0,1,8 / 0,1,9.
  - In state 8: PCWriteCond=1, ALUOp=1, PCSource=1.
  - In state 9: PCWrite=1, PCSource=2.
- Illegal opcode 6'b111111 → state 0,1,0, illegal=1 and remaining 1 through a subsequent addi (0,1,10,11,0). illegal clears on clr.
- Reset mid-MEMRD with memready=0 → the next state is 0 and MemWrite/RegWrite never pulse.
